// File: rtl/snake_step_scheduler.sv
// Step pacing for the snake during PLAY: periodic STEP strobe, direction commit
// with reversal rejection, and level-driven speed-up as targets are eaten.
module snake_step_scheduler #(
   parameter int unsigned BASE_PERIOD       = 25_000_000,
   parameter int unsigned PERIOD_DEC        = 2_500_000,
   parameter int unsigned MAX_LEVEL         = 7,
   parameter int unsigned TARGETS_PER_LEVEL = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] MSM_STATE,
   input  logic       BTNU,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       BTNR,
   input  logic       TARGET_REACHED,
   output logic       STEP,
   output logic [1:0] DIR,
   output logic [2:0] LEVEL
);

   typedef enum logic [1:0] {
      MSM_START    = 2'b00,
      MSM_PLAY     = 2'b01,
      MSM_LOSS     = 2'b10,
      MSM_LOSS_ALT = 2'b11
   } msm_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   localparam logic [2:0] MAX_LVL  = 3'(MAX_LEVEL);
   localparam logic [3:0] TGT_LAST = 4'(TARGETS_PER_LEVEL - 1);

   msm_t        msm;
   dir_t        dir_q;
   dir_t        pending;
   dir_t        pending_next;
   logic [31:0] count;
   logic [31:0] period;
   logic [3:0]  tcnt;
   logic [2:0]  level;
   logic        step_q;
   logic        terminal;

   assign msm    = msm_t'(MSM_STATE);
   assign period = 32'(BASE_PERIOD) - 32'(level) * 32'(PERIOD_DEC);
   // >= rather than == so a mid-period speed-up ends the period at once
   assign terminal = (count >= period - 32'd1);

   // Reversals are judged against the committed direction, not the pending one
   always_comb begin
      pending_next = pending;
      if (BTNU && dir_q != DIR_DOWN)
         pending_next = DIR_UP;
      else if (BTND && dir_q != DIR_UP)
         pending_next = DIR_DOWN;
      else if (BTNL && dir_q != DIR_RIGHT)
         pending_next = DIR_LEFT;
      else if (BTNR && dir_q != DIR_LEFT)
         pending_next = DIR_RIGHT;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count   <= '0;
         tcnt    <= '0;
         level   <= '0;
         step_q  <= 1'b0;
         dir_q   <= DIR_RIGHT;
         pending <= DIR_RIGHT;
      end else begin
         step_q <= 1'b0;
         case (msm)
            MSM_START: begin
               count   <= '0;
               tcnt    <= '0;
               level   <= '0;
               dir_q   <= DIR_RIGHT;
               pending <= DIR_RIGHT;
            end
            MSM_PLAY: begin
               pending <= pending_next;
               if (terminal) begin
                  count  <= '0;
                  step_q <= 1'b1;
                  dir_q  <= pending;
               end else begin
                  count <= count + 32'd1;
               end
               if (TARGET_REACHED) begin
                  if (tcnt >= TGT_LAST) begin
                     tcnt <= '0;
                     if (level < MAX_LVL)
                        level <= level + 3'd1;
                  end else begin
                     tcnt <= tcnt + 4'd1;
                  end
               end
            end
            default: begin
               // LOSS keeps direction and level visible; only pacing stops
               count <= '0;
            end
         endcase
      end
   end

   assign STEP  = step_q;
   assign DIR   = dir_q;
   assign LEVEL = level;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler: directed scenarios plus random play, every
// cycle compared against a behavioural model of the scheduling rules.
module tb_snake_step_scheduler;

   localparam int unsigned BASE = 10;
   localparam int unsigned DEC  = 2;
   localparam int unsigned MAXL = 3;
   localparam int unsigned TPL  = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [1:0] MSM_STATE = 2'b00;
   logic       BTNU = 1'b0;
   logic       BTND = 1'b0;
   logic       BTNL = 1'b0;
   logic       BTNR = 1'b0;
   logic       TARGET_REACHED = 1'b0;
   logic       STEP;
   logic [1:0] DIR;
   logic [2:0] LEVEL;

   int checks = 0;
   int errors = 0;

   // Model state: elapsed cycles in period, targets eaten, level, directions
   int m_count = 0;
   int m_tcnt  = 0;
   int m_level = 0;
   int m_dir   = 1;
   int m_pend  = 1;
   int m_step  = 0;

   snake_step_scheduler #(
      .BASE_PERIOD(BASE),
      .PERIOD_DEC(DEC),
      .MAX_LEVEL(MAXL),
      .TARGETS_PER_LEVEL(TPL)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .MSM_STATE(MSM_STATE),
      .BTNU(BTNU),
      .BTND(BTND),
      .BTNL(BTNL),
      .BTNR(BTNR),
      .TARGET_REACHED(TARGET_REACHED),
      .STEP(STEP),
      .DIR(DIR),
      .LEVEL(LEVEL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Next state from the rules: a period is BASE - level*DEC cycles, the reverse
   // of a direction d is (d+2) mod 4, buttons scanned U, D, L, R.
   task automatic model_next();
      int  period;
      int  rev;
      int  nd;
      int  np;
      bit  btn [4];
      int  code [4];
      code = '{0, 2, 3, 1};
      btn  = '{BTNU, BTND, BTNL, BTNR};
      if (RESET || MSM_STATE == 2'b00) begin
         m_count = 0; m_tcnt = 0; m_level = 0;
         m_dir = 1; m_pend = 1; m_step = 0;
      end else if (MSM_STATE == 2'b01) begin
         period = BASE - m_level * DEC;
         rev = (m_dir + 2) % 4;
         np = m_pend;
         for (int i = 0; i < 4; i++) begin
            if (btn[i] && code[i] != rev) begin
               np = code[i];
               break;
            end
         end
         if (m_count + 1 >= period) begin
            m_step = 1; m_count = 0; nd = m_pend;
         end else begin
            m_step = 0; m_count++; nd = m_dir;
         end
         if (TARGET_REACHED) begin
            m_tcnt++;
            if (m_tcnt == TPL) begin
               m_tcnt = 0;
               if (m_level < MAXL) m_level++;
            end
         end
         m_dir  = nd;
         m_pend = np;
      end else begin
         m_count = 0;
         m_step  = 0;
      end
   endtask

   task automatic tick();
      model_next();
      @(posedge CLK);
      #1;
      check("step", STEP, m_step);
      check("dir", DIR, m_dir);
      check("level", LEVEL, m_level);
   endtask

   task automatic wait_step(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (STEP !== 1'b1 && n < 60);
      check("step_seen", STEP, 1);
   endtask

   task automatic pulse_target();
      TARGET_REACHED = 1'b1;
      tick();
      TARGET_REACHED = 1'b0;
   endtask

   initial begin
      int n;
      int steps;
      int md;
      int ml;

      // Reset
      tick();
      tick();
      check("rst_step", STEP, 0);
      check("rst_dir", DIR, 1);
      check("rst_level", LEVEL, 0);

      // 1: first step PERIOD cycles after entering PLAY, then steady spacing
      RESET = 1'b0;
      MSM_STATE = 2'b01;
      wait_step(n);
      check("s1_first_gap", n, 10);
      tick();
      check("s1_one_cycle", STEP, 0);
      wait_step(n);
      check("s1_gap", n, 9);
      check("s1_dir", DIR, 1);
      check("s1_level", LEVEL, 0);

      // 2: LEFT rejected against RIGHT, then UP accepted
      BTNL = 1'b1;
      repeat (3) tick();
      BTNL = 1'b0;
      BTNU = 1'b1;
      tick();
      BTNU = 1'b0;
      wait_step(n);
      check("s2_dir_up", DIR, 0);

      // 3: UP has priority over RIGHT
      BTNR = 1'b1;
      tick();
      BTNR = 1'b0;
      wait_step(n);
      check("s3_dir_right", DIR, 1);
      BTNU = 1'b1;
      BTNR = 1'b1;
      wait_step(n);
      BTNU = 1'b0;
      BTNR = 1'b0;
      check("s3_dir_up", DIR, 0);

      // 4: level climbs every two targets, period shrinks by two
      for (int lv = 1; lv <= 3; lv++) begin
         pulse_target();
         tick();
         tick();
         pulse_target();
         check("s4_level", LEVEL, lv);
         wait_step(n);
         wait_step(n);
         check("s4_gap", n, 10 - 2 * lv);
      end
      pulse_target();
      tick();
      pulse_target();
      check("s4_level_sat", LEVEL, 3);
      wait_step(n);
      wait_step(n);
      check("s4_gap_sat", n, 4);

      // 5: second target at count 7 shortens the period so the step is next edge
      MSM_STATE = 2'b00;
      tick();
      check("s5_start_level", LEVEL, 0);
      MSM_STATE = 2'b01;
      pulse_target();
      wait_step(n);
      repeat (7) tick();
      pulse_target();
      check("s5_level", LEVEL, 1);
      check("s5_no_step_yet", STEP, 0);
      tick();
      check("s5_step", STEP, 1);

      // 6: LOSS freezes outputs, START restores defaults, RESET mid-period
      BTND = 1'b1;
      tick();
      BTND = 1'b0;
      wait_step(n);
      repeat (3) tick();
      md = m_dir;
      ml = m_level;
      MSM_STATE = 2'b10;
      steps = 0;
      repeat (15) begin
         tick();
         if (STEP === 1'b1) steps++;
      end
      MSM_STATE = 2'b11;
      repeat (5) begin
         tick();
         if (STEP === 1'b1) steps++;
      end
      check("s6_loss_steps", steps, 0);
      check("s6_loss_dir", DIR, md);
      check("s6_loss_level", LEVEL, ml);
      MSM_STATE = 2'b00;
      tick();
      check("s6_start_dir", DIR, 1);
      check("s6_start_level", LEVEL, 0);
      MSM_STATE = 2'b01;
      BTNU = 1'b1;
      wait_step(n);
      BTNU = 1'b0;
      check("s6_play_dir", DIR, 0);
      pulse_target();
      pulse_target();
      tick();
      RESET = 1'b1;
      tick();
      check("s6_rst_step", STEP, 0);
      check("s6_rst_dir", DIR, 1);
      check("s6_rst_level", LEVEL, 0);
      RESET = 1'b0;

      // Random play against the model
      MSM_STATE = 2'b01;
      repeat (3000) begin
         RESET = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 49) == 0)
            MSM_STATE = 2'($urandom_range(0, 3));
         else if (MSM_STATE != 2'b01 && $urandom_range(0, 9) == 0)
            MSM_STATE = 2'b01;
         BTNU = ($urandom_range(0, 5) == 0);
         BTND = ($urandom_range(0, 5) == 0);
         BTNL = ($urandom_range(0, 5) == 0);
         BTNR = ($urandom_range(0, 5) == 0);
         TARGET_REACHED = ($urandom_range(0, 5) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
